// File: rtl/mux_pkg.sv
// Shared definitions for the stream mux/demux family.
//   lane_idx_t : 2-bit lane selector
//   NUM_LANES  : lanes per block
//   LANE_DEPTH : entries buffered per lane
package mux_pkg;

  typedef logic [1:0] lane_idx_t;

  localparam int NUM_LANES  = 4;
  localparam int LANE_DEPTH = 2;

  // Occupancy value at which a lane refuses further pushes.
  localparam logic [1:0] LANE_FULL = 2'(LANE_DEPTH);

endpackage

// File: rtl/demux_lane_fifo.sv
// Two-entry lane FIFO used once per demux output lane.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push         : write push_data this cycle (ignored when full)
//   push_data    : payload written on push
//   pop          : consumer takes the head (ignored when empty)
//   head_valid   : head entry present
//   head_data    : head entry; holds its last value when empty
//   occupancy    : number of stored entries, 0..2
// slot0 is always the head; slot1 is the second entry. Entries shift
// forward only when a pop leaves a second entry behind, so head_data
// stays put while the head is waiting and after the lane drains.
module demux_lane_fifo
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       occ_q, occ_d;
  logic             do_push, do_pop;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    do_push = push && (occ_q != LANE_FULL);
    do_pop  = pop && (occ_q != 2'd0);

    case ({do_push, do_pop})
      2'b10: begin
        if (occ_q == 2'd0) slot0_d = push_data;
        else               slot1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) slot0_d = slot1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new beat lands behind whatever remains.
        if (occ_q == 2'd1) begin
          slot0_d = push_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
    end
  end

  assign head_valid = (occ_q != 2'd0);
  assign head_data  = slot0_q;
  assign occupancy  = occ_q;

endmodule

// File: rtl/demux4_stream.sv
// 1-to-4 valid/ready stream demultiplexer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : producer has a beat
//   in_ready   : beat accepted this cycle if in_valid
//   in_data    : beat payload (WIDTH)
//   in_sel     : destination lane, sampled only on accept
//   out_valid  : per-lane head valid
//   out_ready  : per-lane consumer ready
//   out_data   : lane i payload at [i*WIDTH +: WIDTH]
//   lane_cnt   : lane i saturating accept count at [i*CNT_W +: CNT_W]
// Each lane owns a 2-entry FIFO, so a stalled consumer only blocks
// beats aimed at its own lane. in_ready depends on in_sel and the
// registered occupancy only; out_ready never reaches it combinationally,
// which means a full lane stays closed for the cycle in which it pops.
module demux4_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [1:0]             in_sel,
  output logic [3:0]             out_valid,
  input  logic [3:0]             out_ready,
  output logic [4*WIDTH-1:0]     out_data,
  output logic [4*CNT_W-1:0]     lane_cnt
);

  logic [NUM_LANES-1:0][1:0]       occ;
  logic [NUM_LANES-1:0]            head_valid;
  logic [NUM_LANES-1:0][WIDTH-1:0] head_data;
  logic [NUM_LANES-1:0]            push;
  logic [NUM_LANES-1:0]            pop;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                            accept;
  lane_idx_t                       sel;

  assign sel      = lane_idx_t'(in_sel);
  assign in_ready = !rst && (occ[sel] != LANE_FULL);
  assign accept   = in_valid && in_ready;

  always_comb begin
    push = '0;
    if (accept) push[sel] = 1'b1;
  end

  assign pop = head_valid & out_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane_fifo #(.WIDTH(WIDTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push[i]),
      .push_data  (in_data),
      .pop        (pop[i]),
      .head_valid (head_valid[i]),
      .head_data  (head_data[i]),
      .occupancy  (occ[i])
    );
  end

  // Per-lane accept counters saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (push[i] && (cnt_q[i] != {CNT_W{1'b1}}))
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_valid = head_valid;
  assign out_data  = head_data;
  assign lane_cnt  = cnt_q;

endmodule

// File: tb/tb_demux4_stream.sv
// Directed bench for demux4_stream. Two instances share stimulus: the
// main one (CNT_W=8) and a narrow-counter one (CNT_W=2) for saturation.
module tb_demux4_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_ready;

  logic        in_ready,  in_ready_s;
  logic [3:0]  out_valid, out_valid_s;
  logic [31:0] out_data,  out_data_s;
  logic [31:0] lane_cnt;
  logic [7:0]  lane_cnt_s;

  int tests = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  demux4_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .lane_cnt(lane_cnt)
  );

  demux4_stream #(.WIDTH(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .lane_cnt(lane_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are read there too.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane(input logic [31:0] v, input int i);
    return v[i*8 +: 8];
  endfunction

  logic [7:0] d_tab [4] = '{8'h01, 8'h00, 8'h01, 8'h01};
  logic [1:0] s_tab [4] = '{2'd2, 2'd0, 2'd3, 2'd1};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;

    // Reset and idle
    tick; tick;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_lane_cnt", lane_cnt, 32'd0);
    rst = 1'b0; #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    tick;

    // One beat per lane, all consumers ready: one-hot valid, 1-cycle latency
    out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = d_tab[k]; in_sel = s_tab[k];
      tick;
      check($sformatf("rt_valid%0d", k), {28'd0, out_valid}, 32'(4'b0001 << s_tab[k]));
      check($sformatf("rt_data%0d", k), {24'd0, lane(out_data, int'(s_tab[k]))}, {24'd0, d_tab[k]});
    end
    in_valid = 1'b0;
    tick;
    check("rt_drained", {28'd0, out_valid}, 32'd0);
    check("rt_cnt", lane_cnt, 32'h01010101);

    // Backpressure on lane 2
    out_ready = 4'b1011;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA1; #1;
    check("bp_rdy1", {31'd0, in_ready}, 32'd1);
    tick;
    in_data = 8'hA2; #1;
    check("bp_rdy2", {31'd0, in_ready}, 32'd1);
    tick;
    in_data = 8'hA3; #1;
    check("bp_rdy3_low", {31'd0, in_ready}, 32'd0);
    tick;
    check("bp_head_hold", {24'd0, lane(out_data, 2)}, 32'hA1);
    check("bp_valid2", {31'd0, out_valid[2]}, 32'd1);
    tick;
    check("bp_rdy_still_low", {31'd0, in_ready}, 32'd0);
    check("bp_head_hold2", {24'd0, lane(out_data, 2)}, 32'hA1);
    in_sel = 2'd0; in_data = 8'hB0; #1;
    check("bp_lane0_open", {31'd0, in_ready}, 32'd1);
    tick;
    check("bp_lane0_data", {24'd0, lane(out_data, 0)}, 32'hB0);
    check("bp_lane0_valid", {31'd0, out_valid[0]}, 32'd1);
    // Release lane 2 with the third beat still offered
    in_sel = 2'd2; in_data = 8'hA3; out_ready = 4'hF; #1;
    check("bp_full_no_comb", {31'd0, in_ready}, 32'd0);
    tick;
    check("bp_order2", {24'd0, lane(out_data, 2)}, 32'hA2);
    check("bp_rdy_reopen", {31'd0, in_ready}, 32'd1);
    tick;
    check("bp_order3", {24'd0, lane(out_data, 2)}, 32'hA3);
    in_valid = 1'b0;
    tick;
    check("bp_drained", {28'd0, out_valid}, 32'd0);
    check("bp_cnt", lane_cnt, 32'h01040102);

    // Continuous stream into lane 1: push and pop every cycle at occupancy 1
    in_valid = 1'b1; in_sel = 2'd1;
    for (int k = 0; k < 6; k++) begin
      in_data = 8'h10 + 8'(k); #1;
      check($sformatf("st_rdy%0d", k), {31'd0, in_ready}, 32'd1);
      tick;
      check($sformatf("st_data%0d", k), {23'd0, out_valid[1], lane(out_data, 1)}, {23'd0, 1'b1, 8'h10 + 8'(k)});
    end
    in_valid = 1'b0;
    tick;
    check("st_drained", {31'd0, out_valid[1]}, 32'd0);
    check("st_cnt1", {24'd0, lane(lane_cnt, 1)}, 32'd7);

    // Counter saturation: narrow instance stops at 3
    rst = 1'b1; tick; rst = 1'b0;
    in_valid = 1'b1; in_sel = 2'd3;
    for (int k = 1; k <= 5; k++) begin
      in_data = 8'(k);
      tick;
      check($sformatf("sat_cnt%0d", k), {24'd0, lane_cnt_s}, {24'd0, 2'((k > 3) ? 3 : k), 6'd0});
    end
    in_valid = 1'b0;
    tick; tick;
    check("sat_hold", {24'd0, lane_cnt_s}, 32'h000000C0);
    check("sat_wide", lane_cnt, 32'h05000000);

    // Reset with lanes 0 and 2 full
    out_ready = 4'h0; in_valid = 1'b1;
    in_sel = 2'd0; in_data = 8'h55; tick;
    in_data = 8'h66; tick;
    in_sel = 2'd2; in_data = 8'h77; tick;
    in_data = 8'h88; tick;
    in_valid = 1'b0;
    check("pre_rst_valid", {28'd0, out_valid}, 32'h5);
    check("pre_rst_heads", {lane(out_data, 2), lane(out_data, 0)}, 32'h7755);
    in_valid = 1'b1; in_sel = 2'd1; rst = 1'b1; #1;
    check("rst_blocks_ready", {31'd0, in_ready}, 32'd0);
    tick;
    check("mid_rst_valid", {28'd0, out_valid}, 32'd0);
    check("mid_rst_cnt", lane_cnt, 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    rst = 1'b0; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h99; out_ready = 4'hF;
    tick;
    in_valid = 1'b0;
    check("post_rst_valid", {28'd0, out_valid}, 32'h4);
    check("post_rst_data", {24'd0, lane(out_data, 2)}, 32'h99);
    tick;
    check("post_rst_cnt", lane_cnt, 32'h00010000);
    check("post_rst_empty", {28'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/demux4_stream.md
Name: demux4_stream

Overview:
- 1-to-4 stream demultiplexer with valid/ready handshake; the inverse of the team's 4:1 select muxes.
- Routes each accepted input beat to one of four output lanes, chosen by a 2-bit select sampled with that beat.
- Each lane has a 2-entry FIFO, so one stalled lane never corrupts data already routed to other lanes.
- Sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 1, data bits per beat.
- CNT_W, 8, width of each per-lane saturating transfer counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  WIDTH  beat payload.
- in_sel  input  2  destination lane index {s2,s1}: 0..3; sampled only on accept.
- out_valid  output  4  bit i: lane i head is valid.
- out_ready  input  4  bit i: consumer i takes the head.
- out_data  output  4*WIDTH  lane i payload at bits [i*WIDTH +: WIDTH].
- lane_cnt  output  4*CNT_W  lane i accepted-beat count at [i*CNT_W +: CNT_W], saturating.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - all lane FIFOs empty; out_valid=4'b0000; out_data=0; lane_cnt=0.
  - in_ready=0 during any cycle in which rst is high.
  - Reset mid-operation discards all buffered beats, with no partial output.
- Accept: fires when in_valid && in_ready.
  - in_ready = !rst && (occupancy of lane in_sel < 2).
  - in_ready is combinational from in_sel and registered occupancy only, never from out_ready; there is no comb path from out_ready to in_ready.
- Latency: a beat accepted at edge N is presented on out_valid/out_data of its lane in the cycle after edge N (1 cycle). No bypass path.
- Lane FIFO (2 entries):
  - Push on accept with in_sel==i.
  - Pop when out_valid[i] && out_ready[i].
  - Push and pop in the same cycle: occupancy unchanged, order preserved. At occupancy 1 the new beat becomes head next cycle.
  - A push at occupancy 2 cannot occur, because in_ready is low.
  - A pop at occupancy 0 is ignored.
- out_data[i] holds the head entry while out_valid[i]=1. It is stable until popped and must not change while valid && !ready.
- When out_valid[i]=0, out_data[i] holds its last value; benches must not check it.
- Ordering: per-lane FIFO order is strict. There is no ordering relation between lanes.
- lane_cnt[i]:
  - increments by 1 on each accept routed to lane i.
  - saturates at 2^CNT_W-1 and holds there.
  - cleared only by rst.
- in_sel or in_data changing while in_valid && !in_ready is legal. The block has no producer-stability requirement and nothing is latched until accept.
- All four lanes may pop in the same cycle as an accept.

Decomposition:
- Shared package mux_pkg:
  - typedef lane_idx_t (2-bit).
  - constant NUM_LANES=4.
  - constant LANE_DEPTH=2.
- Sub-module demux_lane_fifo (WIDTH): 2-entry FIFO.
  - Ports: push, push_data, pop, head_valid, head_data, occupancy[1:0].
  - The top instantiates it four times in a generate loop.
  - The top holds in_ready, accept decode and the counters.

Test Plan:
- Reset then idle -> out_valid=0000, lane_cnt all 0, in_ready=0 while rst=1 and 1 afterwards.
- Send data 1,0,1,1 with in_sel=2,0,3,1; all out_ready=1 -> each beat appears on its lane exactly 1 cycle after accept; lane_cnt=1,1,1,1.
- Backpressure:
  - Stimulus: out_ready[2]=0; send 3 beats to lane 2, with in_valid held.
  - Required: in_ready drops after 2 accepts; out_data[2] stays at the first beat.
  - Then send to lane 0 -> accepted immediately.
  - Release out_ready[2] -> order 1st, 2nd, 3rd preserved.
- Simultaneous push/pop on lane 1 at occupancy 1 with continuous traffic -> in_ready stays 1 and one beat per cycle streams, with no loss or duplication.
- Counter saturation with CNT_W=2 -> 5 accepts to lane 3 give lane_cnt[3]=3 that holds; other lanes stay 0.
- Assert rst with lanes 0 and 2 holding 2 beats each -> next cycle out_valid=0000, counters 0; subsequent traffic behaves as after a fresh reset.
